// File: rtl/sram_arbiter_if.sv
// Bundle of both master ports and the SRAM controller port around sram_arbiter.
// slave = arbiter side, master = everything connected to it (masters + SRAM controller).
interface sram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              M0_req;
    logic              M1_req;
    logic              M0_grant;
    logic              M1_grant;
    logic [ADDR_W-1:0] M0_address;
    logic [ADDR_W-1:0] M1_address;
    logic [DATA_W-1:0] M0_write_data;
    logic [DATA_W-1:0] M1_write_data;
    logic              M0_we_n;
    logic              M1_we_n;
    logic [DATA_W-1:0] M0_read_data;
    logic [DATA_W-1:0] M1_read_data;
    logic              M0_read_valid;
    logic              M1_read_valid;
    logic [ADDR_W-1:0] SRAM_address;
    logic [DATA_W-1:0] SRAM_write_data;
    logic              SRAM_we_n;
    logic [DATA_W-1:0] SRAM_read_data;
    logic              ARB_busy;

    modport slave (
        input  M0_req, M1_req,
        input  M0_address, M1_address,
        input  M0_write_data, M1_write_data,
        input  M0_we_n, M1_we_n,
        input  SRAM_read_data,
        output M0_grant, M1_grant,
        output M0_read_data, M1_read_data,
        output M0_read_valid, M1_read_valid,
        output SRAM_address, SRAM_write_data, SRAM_we_n,
        output ARB_busy
    );

    modport master (
        output M0_req, M1_req,
        output M0_address, M1_address,
        output M0_write_data, M1_write_data,
        output M0_we_n, M1_we_n,
        output SRAM_read_data,
        input  M0_grant, M1_grant,
        input  M0_read_data, M1_read_data,
        input  M0_read_valid, M1_read_valid,
        input  SRAM_address, SRAM_write_data, SRAM_we_n,
        input  ARB_busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Burst-based two-master SRAM port arbiter; grant one edge after request, read valid READ_LATENCY after address.
// No backpressure: owner holds the port while requesting; release drains READ_LATENCY cycles. Tie-break: M0, or round robin with SRAM_ARB_ROUND_ROBIN_EN.
module sram_arbiter #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 2
) (
    input logic           Clock,
    input logic           Reset,
    sram_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN0  = 2'd1;
    localparam logic [1:0] S_OWN1  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam int              CNT_W      = 2;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(READ_LATENCY - 1);

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [CNT_W-1:0]        drain_cnt;
    logic [CNT_W-1:0]        drain_cnt_nxt;
    logic                    m0_grant;
    logic                    m1_grant;
    logic [READ_LATENCY-1:0] rd_pipe0;
    logic [READ_LATENCY-1:0] rd_pipe1;
    logic                    pick_m1;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_owner;  // 0 = M0, 1 = M1

    assign pick_m1 = ~last_owner;

    // Reset value M1 makes M0 win the first tie.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_owner <= 1'b1;
        end else if (state == S_IDLE && state_nxt != S_IDLE) begin
            last_owner <= (state_nxt == S_OWN1);
        end
    end
`else
    assign pick_m1 = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            S_IDLE: begin
                if (bus.M0_req && bus.M1_req) begin
                    state_nxt = pick_m1 ? S_OWN1 : S_OWN0;
                end else if (bus.M0_req) begin
                    state_nxt = S_OWN0;
                end else if (bus.M1_req) begin
                    state_nxt = S_OWN1;
                end
            end
            S_OWN0: begin
                if (!bus.M0_req) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            S_OWN1: begin
                if (!bus.M1_req) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
            m0_grant  <= 1'b0;
            m1_grant  <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            m0_grant  <= (state_nxt == S_OWN0);
            m1_grant  <= (state_nxt == S_OWN1);
        end
    end

    // Per-master read tags ride alongside the SRAM read pipeline.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_pipe0 <= '0;
            rd_pipe1 <= '0;
        end else begin
            rd_pipe0[0] <= (state == S_OWN0) && bus.M0_we_n;
            rd_pipe1[0] <= (state == S_OWN1) && bus.M1_we_n;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe0[i] <= rd_pipe0[i-1];
                rd_pipe1[i] <= rd_pipe1[i-1];
            end
        end
    end

    always_comb begin
        bus.SRAM_address    = '0;
        bus.SRAM_write_data = '0;
        bus.SRAM_we_n       = 1'b1;
        case (state)
            S_OWN0: begin
                bus.SRAM_address    = bus.M0_address;
                bus.SRAM_write_data = bus.M0_write_data;
                bus.SRAM_we_n       = bus.M0_we_n;
            end
            S_OWN1: begin
                bus.SRAM_address    = bus.M1_address;
                bus.SRAM_write_data = bus.M1_write_data;
                bus.SRAM_we_n       = bus.M1_we_n;
            end
            default: ;
        endcase
    end

    assign bus.M0_grant      = m0_grant;
    assign bus.M1_grant      = m1_grant;
    assign bus.M0_read_valid = rd_pipe0[READ_LATENCY-1];
    assign bus.M1_read_valid = rd_pipe1[READ_LATENCY-1];
    assign bus.M0_read_data  = bus.SRAM_read_data;
    assign bus.M1_read_data  = bus.SRAM_read_data;
    assign bus.ARB_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM with fixed read latency plus per-master read scoreboards.
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: data for the address of cycle c appears in cycle c+RL.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] ra0, ra1;
    always @(posedge clk) begin
        if (!bus.SRAM_we_n) mem[bus.SRAM_address] <= bus.SRAM_write_data;
        ra0 <= bus.SRAM_address;
        ra1 <= ra0;
    end
    assign bus.SRAM_read_data = mem[ra1];

    always @(negedge clk) begin
        exp_t e;
        if (bus.M0_read_valid) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL m0_unexpected_valid cyc=%0d data=%h", cyc, bus.M0_read_data);
            end else begin
                e = q0.pop_front();
                if (e.due !== cyc || bus.M0_read_data !== e.data) begin
                    errors++;
                    $display("FAIL m0_read got cyc=%0d data=%h want cyc=%0d data=%h",
                             cyc, bus.M0_read_data, e.due, e.data);
                end
            end
        end else if (q0.size() != 0 && q0[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL m0_missing_valid cyc=%0d want data=%h due=%0d", cyc, q0[0].data, q0[0].due);
            void'(q0.pop_front());
        end
        if (bus.M1_read_valid) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL m1_unexpected_valid cyc=%0d data=%h", cyc, bus.M1_read_data);
            end else begin
                e = q1.pop_front();
                if (e.due !== cyc || bus.M1_read_data !== e.data) begin
                    errors++;
                    $display("FAIL m1_read got cyc=%0d data=%h want cyc=%0d data=%h",
                             cyc, bus.M1_read_data, e.due, e.data);
                end
            end
        end else if (q1.size() != 0 && q1[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL m1_missing_valid cyc=%0d want data=%h due=%0d", cyc, q1[0].data, q1[0].due);
            void'(q1.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [DW-1:0] d);
        exp_t e;
        e.due = cyc + RL;
        e.data = d;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [DW-1:0] d);
        exp_t e;
        e.due = cyc + RL;
        e.data = d;
        q1.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.ARB_busy && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.ARB_busy) begin
            errors++;
            $display("FAIL idle_timeout busy=%b want 0", bus.ARB_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.M0_grant, bus.M1_grant, bus.M0_read_valid, bus.M1_read_valid, bus.ARB_busy} !== 5'b0 ||
            bus.SRAM_address !== '0 || bus.SRAM_write_data !== '0 || bus.SRAM_we_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_state g=%b%b v=%b%b busy=%b addr=%h wd=%h we_n=%b want all 0, we_n 1",
                     bus.M0_grant, bus.M1_grant, bus.M0_read_valid, bus.M1_read_valid, bus.ARB_busy,
                     bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_m0_write_read();
        bus.M0_req = 1'b1; bus.M0_address = '0; bus.M0_we_n = 1'b1;
        #1;
        checks++;
        if (bus.M0_grant !== 1'b0 || bus.SRAM_we_n !== 1'b1) begin
            errors++;
            $display("FAIL grant_early grant=%b we_n=%b want 0 1", bus.M0_grant, bus.SRAM_we_n);
        end
        tick();
        checks++;
        if (bus.M0_grant !== 1'b1 || bus.M1_grant !== 1'b0 || bus.ARB_busy !== 1'b1) begin
            errors++;
            $display("FAIL grant_latency g0=%b g1=%b busy=%b want 1 0 1", bus.M0_grant, bus.M1_grant, bus.ARB_busy);
        end
        for (int i = 0; i < 4; i++) begin
            bus.M0_address = AW'(i); bus.M0_write_data = DW'(i); bus.M0_we_n = 1'b0;
            #1;
            checks++;
            if (bus.SRAM_address !== AW'(i) || bus.SRAM_write_data !== DW'(i) || bus.SRAM_we_n !== 1'b0) begin
                errors++;
                $display("FAIL write_mirror addr=%h wd=%h we_n=%b want %h %h 0",
                         bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n, i, i);
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            bus.M0_address = AW'(i); bus.M0_we_n = 1'b1;
            if (i == 3) bus.M0_req = 1'b0;
            #1;
            checks++;
            if (bus.SRAM_address !== AW'(i) || bus.SRAM_we_n !== 1'b1) begin
                errors++;
                $display("FAIL read_mirror addr=%h we_n=%b want %h 1", bus.SRAM_address, bus.SRAM_we_n, i);
            end
            push0(DW'(i));
            tick();
        end
        checks++;
        if (bus.M0_grant !== 1'b0 || bus.SRAM_we_n !== 1'b1 || bus.SRAM_address !== '0 || bus.ARB_busy !== 1'b1) begin
            errors++;
            $display("FAIL release grant=%b we_n=%b addr=%h busy=%b want 0 1 0 1",
                     bus.M0_grant, bus.SRAM_we_n, bus.SRAM_address, bus.ARB_busy);
        end
        wait_idle();
    endtask

    task automatic test_single_cycle_own();
        bus.M0_req = 1'b1; bus.M0_address = AW'(2); bus.M0_we_n = 1'b1;
        tick();
        checks++;
        if (bus.M0_grant !== 1'b1) begin
            errors++;
            $display("FAIL single_grant grant=%b want 1", bus.M0_grant);
        end
        bus.M0_req = 1'b0;
        push0(DW'(2));
        tick();
        checks++;
        if (bus.M0_grant !== 1'b0 || bus.ARB_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_release grant=%b busy=%b want 0 1", bus.M0_grant, bus.ARB_busy);
        end
        wait_idle();
    endtask

    task automatic test_no_preempt_handover();
        bus.M0_req = 1'b1; bus.M0_we_n = 1'b1; bus.M0_address = '0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.M0_address = AW'(i);
            if (i == 1) begin
                bus.M1_req = 1'b1; bus.M1_address = AW'(1); bus.M1_we_n = 1'b1;
            end
            if (i == 3) bus.M0_req = 1'b0;
            #1;
            checks++;
            if (bus.M0_grant !== 1'b1 || bus.M1_grant !== 1'b0) begin
                errors++;
                $display("FAIL no_preempt g0=%b g1=%b want 1 0", bus.M0_grant, bus.M1_grant);
            end
            push0(DW'(i));
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (bus.M0_grant !== 1'b0 || bus.M1_grant !== 1'b0 || bus.SRAM_address !== '0) begin
                errors++;
                $display("FAIL handover_gap%0d g0=%b g1=%b addr=%h want 0 0 0",
                         g, bus.M0_grant, bus.M1_grant, bus.SRAM_address);
            end
            tick();
        end
        checks++;
        if (bus.M1_grant !== 1'b1 || bus.M0_grant !== 1'b0) begin
            errors++;
            $display("FAIL handover_grant g0=%b g1=%b want 0 1", bus.M0_grant, bus.M1_grant);
        end
        bus.M1_req = 1'b0;
        push1(DW'(1));
        #1;
        checks++;
        if (bus.SRAM_address !== AW'(1) || bus.SRAM_we_n !== 1'b1) begin
            errors++;
            $display("FAIL m1_mux addr=%h we_n=%b want 1 1", bus.SRAM_address, bus.SRAM_we_n);
        end
        tick();
        wait_idle();
    endtask

    task automatic test_tie();
        int  gap = 0;
        logic exp1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        bus.M0_req = 1'b1; bus.M0_address = AW'('h10); bus.M0_write_data = 16'hA0A0; bus.M0_we_n = 1'b0;
        bus.M1_req = 1'b1; bus.M1_address = AW'('h20); bus.M1_write_data = 16'hB0B0; bus.M1_we_n = 1'b0;
        tick();
        checks++;
        if (bus.M0_grant !== 1'b1 || bus.M1_grant !== 1'b0 || bus.SRAM_address !== AW'('h10)) begin
            errors++;
            $display("FAIL first_tie g0=%b g1=%b addr=%h want 1 0 10", bus.M0_grant, bus.M1_grant, bus.SRAM_address);
        end
        bus.M0_req = 1'b0;
        tick();
        bus.M0_req = 1'b1;
        while (!bus.M0_grant && !bus.M1_grant && gap < 10) begin
            gap++;
            tick();
        end
        checks++;
        if (gap !== RL + 1) begin
            errors++;
            $display("FAIL tie_gap got %0d want %0d", gap, RL + 1);
        end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp1 = 1'b1;
`else
        exp1 = 1'b0;
`endif
        checks++;
        if (bus.M1_grant !== exp1 || bus.M0_grant !== ~exp1) begin
            errors++;
            $display("FAIL second_tie g0=%b g1=%b want %b %b", bus.M0_grant, bus.M1_grant, ~exp1, exp1);
        end
        bus.M0_req = 1'b0; bus.M1_req = 1'b0;
        tick();
        wait_idle();
    endtask

    task automatic test_reset_midburst();
        bus.M1_req = 1'b1; bus.M1_address = AW'(5); bus.M1_we_n = 1'b1;
        tick();
        checks++;
        if (bus.M1_grant !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_grant grant=%b want 1", bus.M1_grant);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.M0_grant !== 1'b0 || bus.M1_grant !== 1'b0 || bus.SRAM_we_n !== 1'b1 ||
            bus.SRAM_address !== '0 || bus.M1_read_valid !== 1'b0 || bus.ARB_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_midburst g=%b%b we_n=%b addr=%h v1=%b busy=%b want 00 1 0 0 0",
                     bus.M0_grant, bus.M1_grant, bus.SRAM_we_n, bus.SRAM_address, bus.M1_read_valid, bus.ARB_busy);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.M1_grant !== 1'b1) begin
            errors++;
            $display("FAIL regrant grant=%b want 1", bus.M1_grant);
        end
        bus.M1_req = 1'b0; bus.M1_we_n = 1'b0; bus.M1_write_data = 16'h5555;
        tick();
        wait_idle();
        repeat (3) tick();
    endtask

    task automatic test_wrap();
        logic [AW-1:0] addrs [3];
        logic [DW-1:0] datas [3];
        addrs[0] = 18'h3FFFE; addrs[1] = 18'h3FFFF; addrs[2] = 18'h00000;
        datas[0] = 16'hBEEF;  datas[1] = 16'hCAFE;  datas[2] = 16'h1234;
        bus.M1_req = 1'b1; bus.M1_we_n = 1'b0; bus.M1_address = addrs[0]; bus.M1_write_data = datas[0];
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.M1_address = addrs[i]; bus.M1_write_data = datas[i]; bus.M1_we_n = 1'b0;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            bus.M1_address = addrs[i]; bus.M1_we_n = 1'b1;
            if (i == 2) bus.M1_req = 1'b0;
            #1;
            checks++;
            if (bus.SRAM_address !== addrs[i]) begin
                errors++;
                $display("FAIL wrap_addr%0d got %h want %h", i, bus.SRAM_address, addrs[i]);
            end
            push1(datas[i]);
            tick();
        end
        wait_idle();
        repeat (2) tick();
    endtask

    initial begin
        bus.M0_req = 1'b0; bus.M1_req = 1'b0;
        bus.M0_address = '0; bus.M1_address = '0;
        bus.M0_write_data = '0; bus.M1_write_data = '0;
        bus.M0_we_n = 1'b1; bus.M1_we_n = 1'b1;
        test_reset();
        test_m0_write_read();
        test_single_cycle_own();
        test_no_preempt_handover();
        test_tie();
        test_reset_midburst();
        test_wrap();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL pending_reads q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single external SRAM port between two masters: M0, the SRAM BIST engine, and M1, a general client such as the UART or VGA path. Ownership is burst-based. A master keeps its grant for as long as it holds its request, so it can issue back-to-back accesses every cycle. On release, the arbiter drains in-flight reads so that returning data always reaches the master that issued the read. Read data is qualified by a per-master valid that is delayed by the fixed SRAM read latency.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- READ_LATENCY, 2, cycles from read address presented to read data valid at SRAM_read_data (legal range 1–4)

Ports:
- Clock  in  1  single system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- M0_req, M1_req  in  1  ownership request, held for the whole burst
- M0_grant, M1_grant  out  1  registered grant; master may drive the SRAM in any cycle its grant is high
- M0_address, M1_address  in  ADDR_W  access address
- M0_write_data, M1_write_data  in  DATA_W  write data
- M0_we_n, M1_we_n  in  1  active-low write enable; high means read
- M0_read_data, M1_read_data  out  DATA_W  SRAM_read_data fanned out to both masters
- M0_read_valid, M1_read_valid  out  1  read data returned for that master
- SRAM_address  out  ADDR_W  to SRAM controller
- SRAM_write_data  out  DATA_W  to SRAM controller
- SRAM_we_n  out  1  to SRAM controller
- SRAM_read_data  in  DATA_W  from SRAM controller
- ARB_busy  out  1  high in any state other than S_IDLE

## Operation
- States:
  - S_IDLE: no owner.
  - S_OWN0, S_OWN1: M0 or M1 owns the port.
  - S_DRAIN: port quiet for READ_LATENCY cycles.
- S_IDLE:
  - Requests are sampled at the clock edge.
  - Only one requester: go to that master's S_OWNx.
  - Both requesting: choose according to the arbitration policy (see Configuration).
  - Neither requesting: stay in S_IDLE.
- S_OWNx:
  - Grant is held while Mx_req=1.
  - When Mx_req=0 is sampled: grant drops, load the drain counter with READ_LATENCY-1, go to S_DRAIN.
  - The other master's request never preempts the owner.
- S_DRAIN:
  - Counter decrements each cycle; at 0, go to S_IDLE.
  - Arbitration restarts in S_IDLE. S_IDLE always lasts at least one cycle between owners.
- Port mux (combinational from state):
  - In S_OWNx, SRAM_address, SRAM_write_data and SRAM_we_n equal Mx's inputs.
  - In every other state: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1.
- Read return:
  - Two shift registers, each READ_LATENCY deep, one per master.
  - Stage 0 input is (state==S_OWNx && Mx_we_n==1).
  - Mx_read_valid is the last stage.
  - Mx_read_data is always SRAM_read_data.
- A last_owner register records the most recently granted master.

## Timing
- Reset values:
  - State: S_IDLE.
  - Both grants: 0.
  - Both read_valid: 0; all shift stages cleared.
  - SRAM_address: 0. SRAM_write_data: 0. SRAM_we_n: 1.
  - ARB_busy: 0.
  - last_owner: M1, so M0 wins the first tie.
- Grant latency:
  - Mx_req rises before edge k in S_IDLE; Mx_grant is high from edge k.
  - The master's first access appears on SRAM_* in the cycle after edge k.
- Release: Mx_req low sampled at edge k → grant low and SRAM_we_n=1 from edge k.
- Read latency: a read presented in cycle c gives Mx_read_valid=1 in cycle c+READ_LATENCY, with matching SRAM_read_data.
- Owner-to-owner handover:
  - Minimum READ_LATENCY+1 cycles with no owner.
  - With the default latency (2), that is 3 cycles.
- Drain completeness: every read issued by the previous owner returns its valid during S_DRAIN or S_IDLE, never while the next owner holds the port.
- Boundaries:
  - Request dropped in the same cycle the grant rises: exactly 1 owned cycle, then drain.
  - Address wrap from 2^ADDR_W-1 to 0 is passed through untouched.
  - Synchronous Reset mid-burst: all outputs take their reset values at the next edge. In-flight valids are discarded, not delivered.
  - Request held across Reset: re-granted from S_IDLE per normal rules.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined:
  - When both requests are sampled in S_IDLE, grant the master that is not last_owner.
  - last_owner is updated on every grant.
- Macro undefined:
  - Fixed priority: M0 (BIST) always wins a tie.
  - last_owner logic is removed.
- Single-requester behaviour is identical in both builds.

## Test plan
- Reset then M0_req=1 alone → M0_grant=1 one cycle later. M0 writes 0x00000..0x00003 with data equal to address; SRAM_* mirrors each write in the same cycle.
- M0 reads addresses 0..3 back-to-back → M0_read_valid high for 4 consecutive cycles starting 2 cycles after the first address, data 0x0000..0x0003. M1_read_valid stays 0 throughout.
- M0 owns the port and M1_req rises mid-burst → no preemption. After M0_req falls: exactly 3 cycles with no grant, then M1_grant=1. M0's last two reads return during the gap.
- Both requests asserted in S_IDLE after reset → M0 granted. After M0 releases with M0_req re-asserted and M1 still requesting: the RR build grants M1; the fixed-priority build grants M0.
- Reset asserted while M1 has a read outstanding → next cycle: both grants 0, SRAM_we_n=1, SRAM_address=0, and no read_valid pulse for that read.
- M1 bursts address 0x3FFFE, 0x3FFFF, 0x00000 → SRAM_address shows the same three values unmodified, and the three read_valids arrive in order.
